// File: rtl/offchip_sram_spi.sv
// offchip_sram_spi: single-word read/write responder for an external SPI serial
// SRAM (mode 0, sequential byte mode). Each request is one 48-bit frame:
// command byte, 24-bit byte address, then 16 data bits, all MSB first.
module offchip_sram_spi #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        ready,
    output logic [15:0] rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // 48 bits need 96 SCK toggles; the data phase starts at toggle 64 (bit 15)
    localparam logic [6:0] LAST_TOG  = 7'd95;
    localparam logic [6:0] DATA_TOG  = 7'd64;
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [47:0] r_frame;
    logic [7:0]  r_div_cnt;
    logic [6:0]  r_tog_cnt;
    logic        r_sck;
    logic        r_cs_n;
    logic        r_mosi;
    logic        r_ready;
    logic        r_we;
    logic [15:0] r_rdata;
    logic [15:0] r_rx;

    logic        w_accept;
    logic        w_tick;
    logic        w_last_tog;
    logic [47:0] w_frame_init;

    // Reads still send 16 zero data bits so both directions share one frame length
    assign w_frame_init = {(req_we ? 8'h02 : 8'h03), 7'b0, req_addr, 1'b0,
                           (req_we ? req_wdata : 16'h0000)};
    assign w_accept     = (r_state == S_IDLE) && req_valid;
    assign w_tick       = (r_state == S_SHIFT) && (r_div_cnt == DIV_LAST);
    assign w_last_tog   = w_tick && (r_tog_cnt == LAST_TOG);

    assign ready    = r_ready;
    assign rdata    = r_rdata;
    assign spi_cs_n = r_cs_n;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept -> shift 96 toggles -> one release cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last_tog) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Frame shifting, SCK generation, MISO capture and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame   <= '0;
            r_div_cnt <= '0;
            r_tog_cnt <= '0;
            r_sck     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_ready   <= 1'b1;
            r_we      <= 1'b0;
            r_rdata   <= '0;
            r_rx      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_frame   <= w_frame_init;
                        r_we      <= req_we;
                        r_mosi    <= w_frame_init[47];
                        r_cs_n    <= 1'b0;
                        r_ready   <= 1'b0;
                        r_div_cnt <= '0;
                        r_tog_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_tog_cnt <= r_tog_cnt + 7'd1;
                        r_sck     <= ~r_sck;
                        if (!r_sck) begin
                            // Rising edge: SRAM output is stable, sample it
                            if (r_tog_cnt >= DATA_TOG) begin
                                r_rx <= {r_rx[14:0], spi_miso};
                            end
                        end else begin
                            // Falling edge: present the next bit; zeros follow bit 0
                            r_frame <= {r_frame[46:0], 1'b0};
                            r_mosi  <= r_frame[46];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_cs_n    <= 1'b1;
                    r_ready   <= 1'b1;
                    r_mosi    <= 1'b0;
                    r_tog_cnt <= '0;
                    if (!r_we) begin
                        r_rdata <= r_rx;
                    end
                end
                default: begin
                    r_cs_n  <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_offchip_sram_spi.sv
// Bench for offchip_sram_spi: two instances (CLK_DIV=1 and CLK_DIV=3) share clk
// and reset. A byte-addressed SRAM model answers the SPI bus; a word-level
// reference memory supplies the expected read data.
module tb_offchip_sram_spi;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        miso      [2];

    logic        rdy0, cs0, sck0, mosi0;
    logic        rdy1, cs1, sck1, mosi1;
    logic [15:0] rd0, rd1;

    int          sel;
    logic        w_ready, w_cs_n, w_sck, w_mosi;
    logic [15:0] w_rdata;

    int checks;
    int errors;

    logic [7:0]  sram    [int];
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rdata [2];

    offchip_sram_spi #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .ready(rdy0), .rdata(rd0),
        .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso[0])
    );

    offchip_sram_spi #(.CLK_DIV(3)) u_div3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .ready(rdy1), .rdata(rd1),
        .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        w_ready = (sel == 1) ? rdy1  : rdy0;
        w_cs_n  = (sel == 1) ? cs1   : cs0;
        w_sck   = (sel == 1) ? sck1  : sck0;
        w_mosi  = (sel == 1) ? mosi1 : mosi0;
        w_rdata = (sel == 1) ? rd1   : rd0;
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sram_rd(input int key);
        return sram.exists(key) ? sram[key] : 8'h00;
    endfunction

    function automatic logic [15:0] ref_rd(input int key);
        return ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
    endfunction

    // One transaction on instance inst, with the SRAM played cycle by cycle.
    // drop_at: cycle after accept at which a stray write request is pulsed (-1: none).
    // abort_at: cycle after accept at which reset is asserted (-1: none).
    task automatic xact(input int inst, input logic we, input logic [15:0] addr,
                        input logic [15:0] wd, input int drop_at, input int abort_at);
        int d, j, last_edge, rises, falls, hp_bad, cs_bad, busy, bkey;
        logic        prev_sck;
        logic [47:0] cap, exp_frame;
        logic [15:0] rw, exp_rd;
        d = (inst == 0) ? 1 : 3;
        sel = inst;
        exp_frame = {(we ? 8'h02 : 8'h03), 7'h00, addr, 1'b0, (we ? wd : 16'h0000)};
        exp_rd = we ? exp_rdata[inst] : ref_rd(inst * 65536 + int'(addr));
        req_we[inst]    = we;
        req_addr[inst]  = addr;
        req_wdata[inst] = wd;
        req_valid[inst] = 1'b1;
        @(negedge clk);
        req_valid[inst] = 1'b0;
        j = 0; last_edge = 0; rises = 0; falls = 0; hp_bad = 0; cs_bad = 0; busy = 0;
        prev_sck = 1'b0; cap = '0; rw = '0;
        while (w_ready == 1'b0 && j < 2000) begin
            busy++;
            if (w_cs_n !== 1'b0) cs_bad++;
            if (w_sck && !prev_sck) begin
                rises++;
                cap = {cap[46:0], w_mosi};
                if (j - last_edge != d) hp_bad++;
                last_edge = j;
            end else if (!w_sck && prev_sck) begin
                falls++;
                if (j - last_edge != d) hp_bad++;
                last_edge = j;
                if (rises == 32) begin
                    bkey = inst * (1 << 20) + int'(cap[23:0]);
                    rw = (cap[31:24] == 8'h03) ? {sram_rd(bkey), sram_rd(bkey + 1)} : 16'h0000;
                end
                miso[inst] = (rises >= 32 && rises < 48) ? rw[47 - rises] : 1'b0;
            end
            prev_sck = w_sck;
            if (j == drop_at) begin
                req_we[inst] = 1'b1; req_addr[inst] = 16'h0055;
                req_wdata[inst] = 16'hDEAD; req_valid[inst] = 1'b1;
            end
            if (j == drop_at + 1) req_valid[inst] = 1'b0;
            if (j == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_cs_n", 48'(w_cs_n), 48'd1);
                check("abort_sck", 48'(w_sck), 48'd0);
                check("abort_ready", 48'(w_ready), 48'd1);
                check("abort_rdata", 48'(w_rdata), 48'd0);
                exp_rdata[0] = '0;
                exp_rdata[1] = '0;
                miso[inst] = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            j++;
        end
        miso[inst] = 1'b0;
        check($sformatf("busy_cycles_i%0d", inst), 48'(busy), 48'(96 * d + 1));
        check("cs_n_low_in_frame", 48'(cs_bad), 48'd0);
        check("sck_half_period", 48'(hp_bad), 48'd0);
        check("sck_rises", 48'(rises), 48'd48);
        check("sck_falls", 48'(falls), 48'd48);
        check("mosi_frame", cap, exp_frame);
        check("end_cs_n", 48'(w_cs_n), 48'd1);
        check("end_sck", 48'(w_sck), 48'd0);
        check("end_mosi", 48'(w_mosi), 48'd0);
        check(we ? "rdata_hold_wr" : "rdata_read", 48'(w_rdata), 48'(exp_rd));
        exp_rdata[inst] = exp_rd;
        // SRAM commits a complete write frame when CS rises
        if (rises == 48 && cap[47:40] == 8'h02) begin
            bkey = inst * (1 << 20) + int'(cap[39:16]);
            sram[bkey]     = cap[15:8];
            sram[bkey + 1] = cap[7:0];
        end
        if (we) ref_mem[inst * 65536 + int'(addr)] = wd;
    endtask

    initial begin
        int cs_low;
        logic [15:0] pool [5];
        checks = 0; errors = 0; sel = 0;
        pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'hFFFF;
        pool[3] = 16'h1234; pool[4] = 16'h0ABC;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; miso[i] = 1'b0; exp_rdata[i] = '0;
        end
        // Preload word 1 of the CLK_DIV=1 SRAM with 0xBEEF (big-endian bytes)
        sram[2] = 8'hBE;
        sram[3] = 8'hEF;
        ref_mem[1] = 16'hBEEF;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            check("rst_ready", 48'(w_ready), 48'd1);
            check("rst_cs_n", 48'(w_cs_n), 48'd1);
            check("rst_sck", 48'(w_sck), 48'd0);
            check("rst_mosi", 48'(w_mosi), 48'd0);
            check("rst_rdata", 48'(w_rdata), 48'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        sel = 0;
        #1;
        check("idle_ready", 48'(w_ready), 48'd1);
        check("idle_cs_n", 48'(w_cs_n), 48'd1);
        @(negedge clk);

        // Directed write and read at CLK_DIV=1, with a stray request mid-read
        xact(0, 1'b1, 16'h0ABC, 16'h1234, -1, -1);
        xact(0, 1'b0, 16'h0001, 16'h0000, 40, -1);
        cs_low = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (cs0 !== 1'b1 || rdy0 !== 1'b1) cs_low++;
        end
        check("no_second_xact", 48'(cs_low), 48'd0);
        xact(0, 1'b0, 16'h0055, 16'h0000, -1, -1);

        // Back-to-back write then read of the same word at CLK_DIV=3
        xact(1, 1'b1, 16'h2222, 16'(($urandom)), -1, -1);
        xact(1, 1'b0, 16'h2222, 16'h0000, -1, -1);

        // Reset during the data phase of a write, then a fresh read
        xact(0, 1'b1, 16'h0300, 16'hA5A5, -1, 70);
        xact(0, 1'b0, 16'h0001, 16'h0000, -1, -1);

        // Randomized traffic on both instances
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 2; i++) begin
                xact(i, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)],
                     16'($urandom), -1, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/offchip_sram_spi.md
# offchip_sram_spi

Off-chip memory responder for the guitar-pedal audio memory path. Accepts one 16-bit word read or write request from the memory controller, runs the transaction on an external SPI serial SRAM (23LC1024-class, SPI mode 0, sequential byte mode), and returns read data together with the ready flag. The ready output drives the controller's `off_chip_mem_ready` input.

## Interface
- `CLK_DIV`, default 1: SCK half-period in `clk` cycles. Legal values are 1 to 255.
- `clk`  input  1: system clock.
- `reset`  input  1: asynchronous, active-high reset.
- `req_valid`  input  1: request present. Sampled only while `ready`=1.
- `req_we`  input  1: 1 = write, 0 = read.
- `req_addr`  input  16: word address.
- `req_wdata`  input  16: write data.
- `ready`  output  1: idle and able to accept a request. Also signals that the previous transaction is complete.
- `rdata`  output  16: last word read. Held until the next read completes.
- `spi_cs_n`  output  1: chip select, active low.
- `spi_sck`  output  1: serial clock, idle low.
- `spi_mosi`  output  1: serial data out.
- `spi_miso`  input  1: serial data in.
- Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- The block has three states.
  - IDLE: `ready`=1, `spi_cs_n`=1, `spi_sck`=0.
  - SHIFT: shifting the 48-bit frame.
  - DONE: one-cycle release.
- Accept rule: `req_valid`=1 with `ready`=1 at a clk edge. On that edge:
  - latch `req_we`, `req_addr` and `req_wdata`;
  - `ready`<=0, `spi_cs_n`<=0;
  - `spi_mosi`<=frame bit 47;
  - go to SHIFT.
- While not in IDLE, the request inputs are ignored. `req_valid` while `ready`=0 is dropped; there is no queueing.
- Frame is 48 bits, MSB first:
  - command byte: 0x02 for a write, 0x03 for a read;
  - 24-bit byte address = {7'b0, addr, 1'b0};
  - 16 data bits.
- Words are big-endian: the high byte goes to byte address 2a, the low byte to 2a+1.
- Write data bits are `req_wdata`[15:0]. During a read, MOSI drives 0 in the data phase.
- SHIFT phase:
  - SCK toggles every `CLK_DIV` clk cycles, starting low, for 96 toggles (48 bits).
  - `spi_mosi` updates to the next bit on the clk edge that drives SCK low (except for bit 47, which was set at accept).
  - `spi_miso` is sampled on the clk edge that drives SCK high, during bits 15..0 only.
- After the 96th toggle (SCK returns low), go to DONE.
- DONE, on the next edge:
  - `spi_cs_n`<=1, `ready`<=1, `spi_mosi`<=0;
  - `rdata`<=assembled word, for reads only;
  - go to IDLE.
- A write never modifies `rdata`.
- Reset values: `ready`=1, `rdata`=0, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, state IDLE, all counters 0.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous) and the frame is abandoned. External SRAM contents for a partial write are undefined.

## Timing
- Accept at edge N. SCK edges fall at N+k·`CLK_DIV`, for k=1..96.
- `spi_cs_n` rises and `ready` rises at edge N+96·`CLK_DIV`+1.
- Busy time: `ready` is low for 96·`CLK_DIV`+1 cycles. That is 97 cycles at `CLK_DIV`=1.
- `rdata` becomes valid in the same cycle that `ready` returns to 1.
- Back-to-back requests: a new accept is possible at edge N+96·`CLK_DIV`+2. This guarantees `spi_cs_n` is high for at least 1 clk cycle between frames.
- CS setup before the first SCK rise is `CLK_DIV` cycles. CS hold after the last SCK fall is 1 cycle.

## Test plan
- Reset:
  - assert `reset` mid-idle → `ready`=1, `spi_cs_n`=1, `spi_sck`=0, `rdata`=0;
  - release → stays idle with `req_valid`=0.
- Write at `CLK_DIV`=1: addr 0x0ABC, wdata 0x1234.
  - MOSI stream 0x02 00 15 78 12 34.
  - `ready` is low for exactly 97 cycles.
  - `rdata` is unchanged.
- Read at `CLK_DIV`=1: addr 0x0001. SRAM model returns 0xBE then 0xEF.
  - MOSI stream 0x03 00 00 02, then 16 zeros.
  - `rdata`=0xBEEF when `ready` rises.
- Busy drop: pulse `req_valid` (write, addr 0x0055) mid-read.
  - The frame is unaffected.
  - No second transaction occurs.
  - The model sees only the read.
- `CLK_DIV`=3, back-to-back: write followed immediately by read of the same address.
  - SCK half-period is 3 cycles.
  - `ready` is low for 289 cycles per request.
  - `spi_cs_n` is high for exactly 1 cycle between frames.
  - The read returns the written word.
- Reset during the SHIFT data phase of a write:
  - `spi_cs_n`=1 and `spi_sck`=0 in the same cycle as reset;
  - after release, a fresh read completes normally in 97 cycles.
